// File: rtl/video_ram_dma_pkg.sv
// Shared constants for video_ram_dma: engine state encoding, stride reset value, op mode codes.
package video_ram_dma_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_FILL    = 3'd1;
    localparam logic [2:0] ST_COPY_RD = 3'd2;
    localparam logic [2:0] ST_COPY_WR = 3'd3;
    localparam logic [2:0] ST_FINISH  = 3'd4;

    localparam int unsigned STRIDE_RESET = 1;

    localparam logic OP_FILL = 1'b0;
    localparam logic OP_COPY = 1'b1;

endpackage

// File: rtl/video_ram_dp.sv
// True dual-port block RAM: port A read/write, port B read-only, both read-first with registered outputs.
module video_ram_dp #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0] din_a,
    output logic [DATA_WIDTH-1:0] dout_a,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    output logic [DATA_WIDTH-1:0] dout_b
);

    logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (we_a) mem[addr_a] <= din_a;
    end

    // Only the output registers reset; the array keeps its contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_a <= '0;
            dout_b <= '0;
        end else begin
            dout_a <= mem[addr_a];
            dout_b <= mem[addr_b];
        end
    end

endmodule

// File: rtl/video_ram_dma.sv
// Video RAM with host pointer front end and fill/copy DMA engine sharing port A.
// Optional descending operation enabled by macro VIDEO_RAM_DMA_DESCENDING_EN.
module video_ram_dma
    import video_ram_dma_pkg::*;
#(
    parameter int ADDR_WIDTH   = 15,
    parameter int DATA_WIDTH   = 8,
    parameter int STRIDE_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   vid_addr,
    output logic [DATA_WIDTH-1:0]   vid_dout,
    input  logic                    ptr_we,
    input  logic [ADDR_WIDTH-1:0]   ptr_din,
    input  logic                    stride_we,
    input  logic [STRIDE_WIDTH-1:0] stride_din,
    input  logic                    data_we,
    input  logic [DATA_WIDTH-1:0]   data_din,
    input  logic                    data_re,
    output logic [DATA_WIDTH-1:0]   data_dout,
    output logic                    data_valid,
    output logic                    host_drop,
    output logic [ADDR_WIDTH-1:0]   ptr,
    input  logic                    op_start,
    input  logic                    op_copy,
    input  logic                    op_dir,
    input  logic [ADDR_WIDTH-1:0]   op_src,
    input  logic [ADDR_WIDTH-1:0]   op_dst,
    input  logic [ADDR_WIDTH-1:0]   op_len,
    input  logic [DATA_WIDTH-1:0]   op_fill,
    output logic                    busy,
    output logic                    done
);

    localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

    logic [2:0]              state;
    logic [STRIDE_WIDTH-1:0] stride;
    logic [ADDR_WIDTH-1:0]   src, dst, cnt, step_val;
    logic [DATA_WIDTH-1:0]   fill_val, data_hold;
    logic                    we_a;
    logic [ADDR_WIDTH-1:0]   addr_a;
    logic [DATA_WIDTH-1:0]   din_a, dout_a;
    logic                    idle, host_acc;

    assign idle     = (state == ST_IDLE);
    assign host_acc = data_we | data_re;
    assign busy     = !idle;
    assign done     = (state == ST_FINISH);

`ifdef VIDEO_RAM_DMA_DESCENDING_EN
    logic dir;
    assign step_val = dir ? '1 : ONE;
`else
    logic unused_dir;
    assign unused_dir = op_dir;
    assign step_val   = ONE;
`endif

    // Host read data is shown straight from the RAM register on the valid cycle, then held.
    assign data_dout = data_valid ? dout_a : data_hold;

    always_comb begin
        we_a   = 1'b0;
        addr_a = ptr;
        din_a  = data_din;
        case (state)
            ST_IDLE:    we_a = data_we;
            ST_FILL:    begin we_a = 1'b1; addr_a = dst; din_a = fill_val; end
            ST_COPY_RD: addr_a = src;
            ST_COPY_WR: begin we_a = 1'b1; addr_a = dst; din_a = dout_a; end
            default:    ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            ptr        <= '0;
            stride     <= STRIDE_WIDTH'(STRIDE_RESET);
            data_valid <= 1'b0;
            host_drop  <= 1'b0;
            data_hold  <= '0;
        end else begin
            data_valid <= idle && data_re && !data_we;
            host_drop  <= !idle && host_acc;
            if (data_valid) data_hold <= dout_a;
            if (stride_we)  stride <= stride_din;
            if (ptr_we)
                ptr <= ptr_din;
            else if (idle && host_acc)
                ptr <= ptr + ADDR_WIDTH'(stride);
            case (state)
                ST_IDLE: if (op_start)
                    state <= (op_len == '0)       ? ST_FINISH  :
                             (op_copy == OP_COPY) ? ST_COPY_RD : ST_FILL;
                ST_FILL:    if (cnt == ONE) state <= ST_FINISH;
                ST_COPY_RD: state <= ST_COPY_WR;
                ST_COPY_WR: state <= (cnt == ONE) ? ST_FINISH : ST_COPY_RD;
                default:    state <= ST_IDLE;
            endcase
        end
    end

    // Operand registers carry no reset; they are only read outside IDLE.
    always_ff @(posedge clk) begin
        case (state)
            ST_IDLE: if (op_start) begin
                src      <= op_src;
                dst      <= op_dst;
                cnt      <= op_len;
                fill_val <= op_fill;
`ifdef VIDEO_RAM_DMA_DESCENDING_EN
                dir      <= op_dir;
`endif
            end
            ST_FILL: begin
                dst <= dst + step_val;
                cnt <= cnt - ONE;
            end
            ST_COPY_WR: begin
                src <= src + step_val;
                dst <= dst + step_val;
                cnt <= cnt - ONE;
            end
            default: ;
        endcase
    end

    video_ram_dp #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk    (clk),
        .rst_n  (rst_n),
        .we_a   (we_a),
        .addr_a (addr_a),
        .din_a  (din_a),
        .dout_a (dout_a),
        .addr_b (vid_addr),
        .dout_b (vid_dout)
    );

endmodule

// File: tb/tb_video_ram_dma.sv
// Bench for video_ram_dma: host vector table, randomized host traffic against a memory model, DMA sequences.
module tb_video_ram_dma;

    localparam int AW = 15;
    localparam int DW = 8;
    localparam int SW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] vid_addr = '0;
    logic [DW-1:0] vid_dout;
    logic          ptr_we = 1'b0;
    logic [AW-1:0] ptr_din = '0;
    logic          stride_we = 1'b0;
    logic [SW-1:0] stride_din = '0;
    logic          data_we = 1'b0;
    logic [DW-1:0] data_din = '0;
    logic          data_re = 1'b0;
    logic [DW-1:0] data_dout;
    logic          data_valid, host_drop, busy, done;
    logic [AW-1:0] ptr;
    logic          op_start = 1'b0, op_copy = 1'b0, op_dir = 1'b0;
    logic [AW-1:0] op_src = '0, op_dst = '0, op_len = '0;
    logic [DW-1:0] op_fill = '0;

    video_ram_dma #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRIDE_WIDTH(SW)) dut (
        .clk(clk), .rst_n(rst_n), .vid_addr(vid_addr), .vid_dout(vid_dout),
        .ptr_we(ptr_we), .ptr_din(ptr_din), .stride_we(stride_we), .stride_din(stride_din),
        .data_we(data_we), .data_din(data_din), .data_re(data_re), .data_dout(data_dout),
        .data_valid(data_valid), .host_drop(host_drop), .ptr(ptr),
        .op_start(op_start), .op_copy(op_copy), .op_dir(op_dir), .op_src(op_src),
        .op_dst(op_dst), .op_len(op_len), .op_fill(op_fill), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: plain memory image plus host pointer/stride/read-hold state.
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    bit            known   [0:(1<<AW)-1];
    logic [AW-1:0] m_ptr    = '0;
    logic [SW-1:0] m_stride = 8'd1;
    logic [DW-1:0] m_dout   = '0;
    bit            m_dout_known = 1'b1;

    typedef struct {
        logic pwe; logic [AW-1:0] pdin; logic swe; logic [SW-1:0] sdin;
        logic we;  logic [DW-1:0] din;  logic re;
        logic [AW-1:0] eptr; logic evalid; logic [DW-1:0] edout;
    } vec_t;
    vec_t vt [17];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // One idle-state host cycle; the model follows the host access rules directly.
    task automatic host_cycle(input logic pwe, input logic [AW-1:0] pdin, input logic swe,
                              input logic [SW-1:0] sdin, input logic we, input logic [DW-1:0] din,
                              input logic re, input logic [AW-1:0] va, input bit chk_on);
        logic [DW-1:0] ev;
        bit            evk;
        logic          exp_valid;
        ptr_we = pwe; ptr_din = pdin; stride_we = swe; stride_din = sdin;
        data_we = we; data_din = din; data_re = re; vid_addr = va;
        ev  = ref_mem[va];
        evk = known[va];
        exp_valid = re && !we;
        if (we) begin
            ref_mem[m_ptr] = din;
            known[m_ptr]   = 1'b1;
        end
        if (exp_valid) begin
            m_dout       = ref_mem[m_ptr];
            m_dout_known = known[m_ptr];
        end
        if (pwe)           m_ptr = pdin;
        else if (we || re) m_ptr = m_ptr + AW'(m_stride);
        if (swe) m_stride = sdin;
        step();
        ptr_we = 1'b0; stride_we = 1'b0; data_we = 1'b0; data_re = 1'b0;
        if (chk_on) begin
            chk("host_ptr", 32'(ptr), 32'(m_ptr));
            chk("host_valid", 32'(data_valid), 32'(exp_valid));
            chk("host_drop_idle", 32'(host_drop), 32'd0);
            if (m_dout_known) chk("host_dout", 32'(data_dout), 32'(m_dout));
            if (evk)          chk("vid_dout", 32'(vid_dout), 32'(ev));
        end
    endtask

    task automatic preload(input logic [AW-1:0] lo, input int n);
        host_cycle(1'b1, lo, 1'b1, 8'd1, 1'b0, 8'h00, 1'b0, lo, 1'b1);
        for (int i = 0; i < n; i++)
            host_cycle(1'b0, '0, 1'b0, '0, 1'b1, 8'($urandom), 1'b0, lo, 1'b1);
    endtask

    task automatic check_region(input string nm, input logic [AW-1:0] lo, input int n);
        logic [AW-1:0] a;
        for (int i = 0; i < n; i++) begin
            a = lo + AW'(i);
            vid_addr = a;
            step();
            if (known[a]) chk($sformatf("%s_%0h", nm, a), 32'(vid_dout), 32'(ref_mem[a]));
        end
    endtask

    task automatic run_op(input string nm, input logic cp, input logic dr, input logic [AW-1:0] src,
                          input logic [AW-1:0] dst, input logic [AW-1:0] len, input logic [DW-1:0] fv,
                          input bit sweep, input bit poke);
        int            bc, dc, idx, exp_bc;
        logic [AW-1:0] a, sa, da, st;
        logic [DW-1:0] ev;
        op_copy = cp; op_dir = dr; op_src = src; op_dst = dst; op_len = len; op_fill = fv;
        op_start = 1'b1;
        step();
        op_start = 1'b0;
        chk({nm, "_busy_start"}, 32'(busy), 32'd1);
        bc = 0; dc = 0;
        while (busy) begin
            if (bc >= 200) begin
                total++; bad++;
                $display("FAIL %s_timeout busy=%0d after %0d cycles", nm, busy, bc);
                break;
            end
            if (done) dc++;
            bc++;
            if (sweep) begin
                idx = bc - 1;
                a = (idx < int'(len)) ? dst + AW'(idx) : dst + len - AW'(1);
                vid_addr = a;
                ev = ref_mem[a];
                step();
                chk($sformatf("%s_sweep%0d", nm, idx), 32'(vid_dout), 32'(ev));
                if (idx < int'(len)) begin
                    ref_mem[a] = fv;
                    known[a]   = 1'b1;
                end
            end else if (poke && bc == 4) begin
                data_we = 1'b1; data_din = 8'hEE;
                op_start = 1'b1; op_copy = 1'b0; op_dst = m_ptr; op_len = 15'd4; op_fill = 8'hEE;
                step();
                data_we = 1'b0; op_start = 1'b0;
                chk({nm, "_host_drop"}, 32'(host_drop), 32'd1);
                chk({nm, "_ptr_held"}, 32'(ptr), 32'(m_ptr));
            end else begin
                step();
            end
        end
        chk({nm, "_done_after"}, 32'(done), 32'd0);
        exp_bc = (len == '0) ? 1 : (cp ? 2 * int'(len) + 1 : int'(len) + 1);
        chk({nm, "_busy_cycles"}, 32'(bc), 32'(exp_bc));
        chk({nm, "_done_count"}, 32'(dc), 32'd1);
        st = AW'(1);
`ifdef VIDEO_RAM_DMA_DESCENDING_EN
        if (dr) st = '1;
`endif
        sa = src; da = dst;
        for (int i = 0; i < int'(len); i++) begin
            ref_mem[da] = cp ? ref_mem[sa] : fv;
            known[da]   = cp ? known[sa] : 1'b1;
            sa = sa + st;
            da = da + st;
        end
    endtask

    initial begin
        vt[0]  = '{1'b0, 15'h0000, 1'b0, 8'h00, 1'b1, 8'h77, 1'b0, 15'h0001, 1'b0, 8'h00};
        vt[1]  = '{1'b0, 15'h0000, 1'b1, 8'h04, 1'b0, 8'h00, 1'b0, 15'h0001, 1'b0, 8'h00};
        vt[2]  = '{1'b1, 15'h0100, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 15'h0100, 1'b0, 8'h00};
        vt[3]  = '{1'b0, 15'h0000, 1'b0, 8'h00, 1'b1, 8'hAA, 1'b0, 15'h0104, 1'b0, 8'h00};
        vt[4]  = '{1'b0, 15'h0000, 1'b0, 8'h00, 1'b1, 8'hBB, 1'b0, 15'h0108, 1'b0, 8'h00};
        vt[5]  = '{1'b0, 15'h0000, 1'b0, 8'h00, 1'b1, 8'hCC, 1'b0, 15'h010C, 1'b0, 8'h00};
        vt[6]  = '{1'b1, 15'h0100, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 15'h0100, 1'b0, 8'h00};
        vt[7]  = '{1'b0, 15'h0000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 15'h0104, 1'b1, 8'hAA};
        vt[8]  = '{1'b0, 15'h0000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 15'h0108, 1'b1, 8'hBB};
        vt[9]  = '{1'b0, 15'h0000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 15'h0108, 1'b0, 8'hBB};
        vt[10] = '{1'b1, 15'h7FFE, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 15'h7FFE, 1'b1, 8'hCC};
        vt[11] = '{1'b0, 15'h0000, 1'b0, 8'h00, 1'b1, 8'h11, 1'b0, 15'h0002, 1'b0, 8'hCC};
        vt[12] = '{1'b1, 15'h0002, 1'b0, 8'h00, 1'b1, 8'h22, 1'b0, 15'h0002, 1'b0, 8'hCC};
        vt[13] = '{1'b0, 15'h0000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 15'h0006, 1'b1, 8'h22};
        vt[14] = '{1'b0, 15'h0000, 1'b0, 8'h00, 1'b1, 8'h33, 1'b1, 15'h000A, 1'b0, 8'h22};
        vt[15] = '{1'b1, 15'h0006, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 15'h0006, 1'b0, 8'h22};
        vt[16] = '{1'b0, 15'h0000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 15'h000A, 1'b1, 8'h33};

        repeat (3) step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ptr", 32'(ptr), 32'd0);
        chk("rst_valid", 32'(data_valid), 32'd0);
        chk("rst_drop", 32'(host_drop), 32'd0);
        chk("rst_vid", 32'(vid_dout), 32'd0);
        chk("rst_dout", 32'(data_dout), 32'd0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 17; i++) begin
            host_cycle(vt[i].pwe, vt[i].pdin, vt[i].swe, vt[i].sdin, vt[i].we, vt[i].din,
                       vt[i].re, 15'h0000, 1'b0);
            chk($sformatf("vec%0d_ptr", i), 32'(ptr), 32'(vt[i].eptr));
            chk($sformatf("vec%0d_valid", i), 32'(data_valid), 32'(vt[i].evalid));
            chk($sformatf("vec%0d_dout", i), 32'(data_dout), 32'(vt[i].edout));
        end

        host_cycle(1'b1, 15'h1000, 1'b1, 8'd1, 1'b0, 8'h00, 1'b0, 15'h1000, 1'b1);
        for (int i = 0; i < 300; i++)
            host_cycle($urandom_range(0, 7) == 0, 15'h1000 + 15'($urandom_range(0, 63)),
                       $urandom_range(0, 15) == 0, 8'($urandom_range(0, 5)),
                       $urandom_range(0, 2) == 0, 8'($urandom), $urandom_range(0, 2) == 0,
                       15'h1000 + 15'($urandom_range(0, 127)), 1'b1);

        preload(15'h01F8, 32);
        run_op("fill", 1'b0, 1'b0, 15'h0000, 15'h0200, 15'd16, 8'h5A, 1'b1, 1'b0);
        check_region("fill_mem", 15'h01F8, 32);

        preload(15'h0200, 8);
        preload(15'h02F8, 24);
        m_ptr = 15'h0208;
        host_cycle(1'b1, 15'h0208, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 15'h0000, 1'b1);
        run_op("copy", 1'b1, 1'b0, 15'h0200, 15'h0300, 15'd8, 8'h00, 1'b0, 1'b1);
        run_op("len0", 1'b0, 1'b0, 15'h0000, 15'h02F8, 15'd0, 8'hFF, 1'b0, 1'b0);
        check_region("copy_mem", 15'h02F8, 24);
        check_region("copy_src", 15'h0200, 16);

        preload(15'h03F0, 64);
        run_op("move", 1'b1, 1'b1, 15'h040F, 15'h0413, 15'd16, 8'h00, 1'b0, 1'b0);
        check_region("move_mem", 15'h03F0, 64);

        preload(15'h04F8, 32);
        op_copy = 1'b0; op_dir = 1'b0; op_dst = 15'h0500; op_len = 15'd16; op_fill = 8'hC3;
        op_start = 1'b1;
        step();
        op_start = 1'b0;
        repeat (5) step();
        chk("abort_busy_before", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_ptr", 32'(ptr), 32'd0);
        chk("abort_vid", 32'(vid_dout), 32'd0);
        for (int i = 0; i < 5; i++) begin
            ref_mem[15'h0500 + 15'(i)] = 8'hC3;
            known[15'h0500 + 15'(i)]   = 1'b1;
        end
        m_ptr = '0; m_stride = 8'd1; m_dout = '0; m_dout_known = 1'b1;
        step();
        rst_n = 1'b1;
        step();
        chk("abort_done_after", 32'(done), 32'd0);
        check_region("abort_mem", 15'h04F8, 32);
        host_cycle(1'b0, '0, 1'b0, '0, 1'b1, 8'h44, 1'b0, 15'h0000, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/video_ram_dma.md
Name: video_ram_dma

Overview:
- Parametrised successor to the dual-port video RAM.
- Port B is a read-only video fetch port with guaranteed 1-cycle latency.
- Port A is owned by a host-access front end (pointer register with programmable stride auto-increment) and by a fill/copy DMA engine.
- Sits between the register file (host side) and the pixel sequencer (video side).

Parameters:
- ADDR_WIDTH, 15, RAM address width; depth = 2**ADDR_WIDTH; all address arithmetic wraps modulo depth.
- DATA_WIDTH, 8, RAM word width.
- STRIDE_WIDTH, 8, width of the auto-increment stride register (unsigned, zero-extended to ADDR_WIDTH).

Ports:
- clk  in  1  single system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- vid_addr  in  ADDR_WIDTH  video fetch address.
- vid_dout  out  DATA_WIDTH  RAM[vid_addr] registered one cycle later.
- ptr_we  in  1  load host pointer from ptr_din.
- ptr_din  in  ADDR_WIDTH  pointer load value.
- stride_we  in  1  load stride from stride_din.
- stride_din  in  STRIDE_WIDTH  stride value.
- data_we  in  1  host write RAM[ptr] <= data_din, then ptr += stride.
- data_din  in  DATA_WIDTH  host write data.
- data_re  in  1  host read RAM[ptr], then ptr += stride.
- data_dout  out  DATA_WIDTH  host read data.
- data_valid  out  1  one-cycle pulse when data_dout is updated.
- host_drop  out  1  one-cycle pulse when data_we/data_re is rejected because the engine is busy.
- ptr  out  ADDR_WIDTH  current host pointer.
- op_start  in  1  start DMA operation (sampled in IDLE only).
- op_copy  in  1  0 = fill, 1 = copy.
- op_dir  in  1  0 = ascending, 1 = descending (see Optional Feature).
- op_src  in  ADDR_WIDTH  copy source start address.
- op_dst  in  ADDR_WIDTH  destination start address.
- op_len  in  ADDR_WIDTH  word count (0 = no-op).
- op_fill  in  DATA_WIDTH  fill value.
- busy  out  1  engine active.
- done  out  1  one-cycle pulse on completion.

Behaviour:
- Reset values: vid_dout=0, data_dout=0, data_valid=0, host_drop=0, ptr=0, stride=1, busy=0, done=0, state=IDLE. RAM contents are not cleared. Reset mid-operation aborts the operation; words already written remain written.
- Video port:
  - Read-only, never stalled, never arbitrated.
  - vid_dout valid 1 cycle after vid_addr.
  - If the same cycle's port-A write targets the same address, vid_dout returns the old data (read-first).
- Host port, IDLE only:
  - data_we: writes in the same cycle; ptr updates on the next edge.
  - data_re: data_dout and data_valid appear 1 cycle later; ptr advances on the same edge as the address is sampled.
  - data_we and data_re asserted together: write wins, and no read occurs.
  - Priority ptr_we > data access. If ptr_we coincides with data_we/data_re, the access uses the old ptr and ptr loads ptr_din (no increment).
  - stride_we is accepted in any state.
  - ptr wraps modulo 2**ADDR_WIDTH.
- Host access while busy:
  - data_we/data_re are ignored and host_drop pulses the next cycle.
  - ptr_we is still accepted.
- Engine FSM states: IDLE, FILL, COPY_RD, COPY_WR, FINISH.
- IDLE:
  - op_start with op_len=0 -> FINISH.
  - op_start with op_copy=0 -> FILL.
  - op_start with op_copy=1 -> COPY_RD.
  - Operands are latched on op_start.
  - busy is asserted from the cycle after op_start up to and including the FINISH cycle.
- FILL: writes op_fill to dst each cycle; dst +/- 1; remaining count decrements. Transitions to FINISH after the last word, giving 1 word per cycle.
- COPY_RD: drives port A with src. Next state is COPY_WR.
- COPY_WR: writes the port-A read data to dst; src and dst step by 1; count decrements. Goes to COPY_RD, or to FINISH after the last word. Throughput is 2 cycles per word.
- FINISH: done pulses for exactly 1 cycle, busy deasserts, then IDLE.
- op_start while busy is ignored.
- Overlapping copy regions are executed literally in the chosen direction. An ascending copy with dst in (src, src+len) smears the source.
- Address counters wrap modulo depth.

Optional Feature:
- Macro VIDEO_RAM_DMA_DESCENDING_EN.
- Defined: op_dir=1 makes src and dst decrement per word. This permits a correct forward-overlap memmove when the start addresses are set to the block ends.
- Undefined: op_dir is ignored, all operations ascend, and the descending logic is not synthesised.

Decomposition:
- Shared package: engine state encoding (IDLE/FILL/COPY_RD/COPY_WR/FINISH), stride reset constant (1), op_copy mode constants.
- One sub-module, video_ram_dp: a parametrised true dual-port block RAM (ADDR_WIDTH/DATA_WIDTH, read-first, registered outputs on both ports).
- The engine and host front end stay in the top module, muxing port A.

Test Plan:
- Reset, then stride_we=4, ptr_we=0x0100, three data_we of AA/BB/CC -> RAM[0x100]=AA, RAM[0x104]=BB, RAM[0x108]=CC; ptr=0x010C.
- ptr=0x7FFE with stride=4, one data_we -> ptr wraps to 0x0002. A following data_re at 0x0002 gives data_valid 1 cycle later with the stored value.
- Fill: dst=0x0200, len=16, fill=0x5A -> busy for 17 cycles (16 FILL + FINISH). RAM[0x200..0x20F]=5A, RAM[0x210] unchanged, done pulses once.
- Copy: src=0x0200, dst=0x0300, len=8 -> done after 2*8+1 busy cycles. A data_we mid-copy produces a host_drop pulse and no RAM change. op_len=0 gives done with no writes.
- Video port: vid_addr swept every cycle while a fill runs on the same addresses -> vid_dout always equals the prior-cycle read-first contents with 1-cycle latency, never stalled.
- With VIDEO_RAM_DMA_DESCENDING_EN: src=0x040F, dst=0x0413, len=16, op_dir=1 -> overlapping block moved intact by +4. Without the macro the same stimulus ascends from 0x040F/0x0413 (wrap-free), confirming op_dir is ignored.
- Assert rst_n mid-fill -> busy=0 immediately, no done pulse, partial writes retained.
